// File: rtl/bitty_pkg.sv
// Shared definitions for the bitty fetch sequencer: state encoding,
// instruction width and the default halt word.
package bitty_pkg;

  localparam int INSTR_W = 16;
  localparam logic [INSTR_W-1:0] HALT_WORD_DEFAULT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_EXEC    = 3'd3,
    ST_NEXT    = 3'd4,
    ST_PAUSE   = 3'd5
  } state_e;

endpackage

// File: rtl/bitty_fetch_sequencer.sv
// Fetches instruction words and hands them one at a time to the bitty control unit.
// Optional single-step pause after every instruction: define BITTY_SINGLE_STEP_EN.
module bitty_fetch_sequencer
  import bitty_pkg::*;
#(
  parameter int                 ADDR_W    = 8,
  parameter logic [INSTR_W-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_addr,
  input  logic               halt_req,
`ifdef BITTY_SINGLE_STEP_EN
  input  logic               step,
`endif
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               run,
  input  logic               done,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               halted,
  output logic [15:0]        instr_count
);

  // state | meaning
  // IDLE    | waiting for start; halted tells whether the last run was stopped
  // FETCH   | read strobe to instruction memory at pc
  // CAPTURE | latch read data; halt word returns to IDLE without executing
  // EXEC    | run high, instr stable, wait for done
  // NEXT    | advance pc and count, honour a pending halt
  // PAUSE   | single-step build only: wait for step or halt_req

  state_e              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [INSTR_W-1:0]  instr_q;
  logic                run_q;
  logic                rd_en_q;
  logic                halted_q;
  logic                halt_pending_q;
  logic [15:0]         instr_count_q;
  logic [15:0]         instr_count_d;

  assign instr_count_d = (instr_count_q == 16'hFFFF) ? instr_count_q : instr_count_q + 16'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      pc_q           <= '0;
      instr_q        <= '0;
      run_q          <= 1'b0;
      rd_en_q        <= 1'b0;
      halted_q       <= 1'b0;
      halt_pending_q <= 1'b0;
      instr_count_q  <= '0;
    end else begin
      rd_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            pc_q           <= start_addr;
            instr_count_q  <= '0;
            halted_q       <= 1'b0;
            halt_pending_q <= 1'b0;
            rd_en_q        <= 1'b1;
            state_q        <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (halt_req) halt_pending_q <= 1'b1;
          state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          instr_q <= mem_rdata;
          if (halt_req) halt_pending_q <= 1'b1;
          if (mem_rdata == HALT_WORD) begin
            halted_q <= 1'b1;
            state_q  <= ST_IDLE;
          end else begin
            run_q   <= 1'b1;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (halt_req) halt_pending_q <= 1'b1;
          // run stays high on the done edge so the control unit can return home
          if (done) begin
            run_q   <= 1'b0;
            state_q <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          pc_q          <= pc_q + ADDR_W'(1);
          instr_count_q <= instr_count_d;
          if (halt_pending_q || halt_req) begin
            halted_q       <= 1'b1;
            halt_pending_q <= 1'b0;
            state_q        <= ST_IDLE;
          end else begin
`ifdef BITTY_SINGLE_STEP_EN
            state_q <= ST_PAUSE;
`else
            rd_en_q <= 1'b1;
            state_q <= ST_FETCH;
`endif
          end
        end
`ifdef BITTY_SINGLE_STEP_EN
        ST_PAUSE: begin
          if (halt_req) begin
            halted_q <= 1'b1;
            state_q  <= ST_IDLE;
          end else if (step) begin
            rd_en_q <= 1'b1;
            state_q <= ST_FETCH;
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_rd_en   = rd_en_q;
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign run         = run_q;
  assign busy        = (state_q != ST_IDLE);
  assign halted      = halted_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_bitty_fetch_sequencer.sv
// Directed bench for bitty_fetch_sequencer with a memory and control-unit model.
// Also exercises the pause/step path when BITTY_SINGLE_STEP_EN is defined.
module tb_bitty_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  start_addr;
  logic        halt_req;
  logic        step;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic [15:0] instr;
  logic        run;
  logic        done;
  logic [7:0]  pc;
  logic        busy;
  logic        halted;
  logic [15:0] instr_count;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:255];
  int          ccnt;
  int          done_at;

  int rd_count, busy_cycles, run_cycles, run_rises, instr_bad, early_drop, done_edges;
  logic [15:0] rise_instr [0:7];
  logic        prev_run, prev_done;
  logic [15:0] prev_instr;
  int b_rd, b_busy, b_runc, b_rise, b_bad, b_drop, b_done;

  bitty_fetch_sequencer #(.ADDR_W(8), .HALT_WORD(16'hFFFF)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .halt_req(halt_req),
`ifdef BITTY_SINGLE_STEP_EN
    .step(step),
`endif
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .instr(instr), .run(run), .done(done), .pc(pc), .busy(busy),
    .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  // control unit: done asserted once run has been high for done_at cycles
  always @(posedge clk or posedge reset) begin
    if (reset) ccnt <= 0;
    else if (run) ccnt <= ccnt + 1;
    else ccnt <= 0;
  end
  assign done = run && (ccnt == done_at);

  initial begin
    rd_count = 0; busy_cycles = 0; run_cycles = 0; run_rises = 0;
    instr_bad = 0; early_drop = 0; done_edges = 0;
    prev_run = 1'b0; prev_done = 1'b0; prev_instr = '0;
  end

  always @(negedge clk) begin
    if (mem_rd_en) rd_count++;
    if (busy) busy_cycles++;
    if (run) run_cycles++;
    if (run && !prev_run) begin
      rise_instr[run_rises % 8] = instr;
      run_rises++;
    end
    if (run && prev_run && instr != prev_instr) instr_bad++;
    if (!run && prev_run && !prev_done) early_drop++;
    if (run && done) done_edges++;
    prev_run   = run;
    prev_done  = done;
    prev_instr = instr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_rd = rd_count; b_busy = busy_cycles; b_runc = run_cycles; b_rise = run_rises;
    b_bad = instr_bad; b_drop = early_drop; b_done = done_edges;
  endtask

  task automatic do_start(input logic [7:0] a);
    @(negedge clk);
    start = 1'b1; start_addr = a;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk({tag, "_idle_timeout"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_run(input logic lvl, input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (run == lvl) break;
    end
    chk({tag, "_run_timeout"}, {31'd0, run}, {31'd0, lvl});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start_addr = '0; halt_req = 1'b0;
    step = 1'b1; done_at = 3;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_run", {31'd0, run}, 0);
    chk("rst_rd_en", {31'd0, mem_rd_en}, 0);
    chk("rst_pc", {24'd0, pc}, 0);
    chk("rst_addr", {24'd0, mem_addr}, 0);
    chk("rst_instr", {16'd0, instr}, 0);
    chk("rst_count", {16'd0, instr_count}, 0);
    chk("rst_halted", {31'd0, halted}, 0);
    reset = 1'b0;

    // halt_req in IDLE does nothing
    @(negedge clk); halt_req = 1'b1;
    @(negedge clk); halt_req = 1'b0;
    @(negedge clk);
    chk("idle_halt_busy", {31'd0, busy}, 0);
    chk("idle_halt_halted", {31'd0, halted}, 0);

    // two instructions then halt word
    mem[0] = 16'h2001; mem[1] = 16'h4005; mem[2] = 16'hFFFF;
    snap();
    do_start(8'h00);
    wait_idle("t1");
    chk("t1_pc", {24'd0, pc}, 32'h2);
    chk("t1_halted", {31'd0, halted}, 1);
    chk("t1_count", {16'd0, instr_count}, 2);
    chk("t1_instr", {16'd0, instr}, 32'hFFFF);
    chk("t1_runs", run_rises - b_rise, 2);
    chk("t1_instr0", {16'd0, rise_instr[b_rise % 8]}, 32'h2001);
    chk("t1_instr1", {16'd0, rise_instr[(b_rise + 1) % 8]}, 32'h4005);
    chk("t1_stable", instr_bad - b_bad, 0);
    chk("t1_drop", early_drop - b_drop, 0);
    chk("t1_rd", rd_count - b_rd, 3);
`ifdef BITTY_SINGLE_STEP_EN
    chk("t1_busy_cycles", busy_cycles - b_busy, 18);
`else
    chk("t1_busy_cycles", busy_cycles - b_busy, 16);
`endif

    // slow control unit, start while busy ignored
    done_at = 6;
    mem[8'h10] = 16'h1234; mem[8'h11] = 16'hFFFF;
    snap();
    do_start(8'h10);
    chk("t2_halted_cleared", {31'd0, halted}, 0);
    wait_run(1'b1, "t2");
    @(negedge clk); start = 1'b1; start_addr = 8'h40;
    @(negedge clk); start = 1'b0;
    wait_idle("t2");
    chk("t2_run_cycles", run_cycles - b_runc, 7);
    chk("t2_done_edges", done_edges - b_done, 1);
    chk("t2_stable", instr_bad - b_bad, 0);
    chk("t2_pc", {24'd0, pc}, 32'h11);
    chk("t2_count", {16'd0, instr_count}, 1);
    chk("t2_drop", early_drop - b_drop, 0);

    // halt request during EXEC at address 5
    done_at = 3;
    mem[5] = 16'h3003; mem[6] = 16'h1111;
    snap();
    do_start(8'h05);
    wait_run(1'b1, "t3");
    @(negedge clk); halt_req = 1'b1;
    @(negedge clk); halt_req = 1'b0;
    wait_idle("t3");
    chk("t3_pc", {24'd0, pc}, 32'h6);
    chk("t3_halted", {31'd0, halted}, 1);
    chk("t3_count", {16'd0, instr_count}, 1);
    chk("t3_done_edges", done_edges - b_done, 1);
    chk("t3_rd", rd_count - b_rd, 1);
    chk("t3_drop", early_drop - b_drop, 0);

    // pc wrap FF -> 00
    mem[8'hFF] = 16'h5555; mem[0] = 16'hFFFF;
    do_start(8'hFF);
    wait_idle("t4");
    chk("t4_pc", {24'd0, pc}, 0);
    chk("t4_count", {16'd0, instr_count}, 1);
    chk("t4_halted", {31'd0, halted}, 1);

    // reset during second EXEC, then clean restart
    mem[8'h20] = 16'h7777; mem[8'h21] = 16'h7778; mem[8'h22] = 16'hFFFF;
    do_start(8'h20);
    wait_run(1'b1, "t5a");
    wait_run(1'b0, "t5b");
    wait_run(1'b1, "t5c");
    chk("t5_count_pre", {16'd0, instr_count}, 1);
    reset = 1'b1;
    #1;
    chk("t5_rst_run", {31'd0, run}, 0);
    chk("t5_rst_rd", {31'd0, mem_rd_en}, 0);
    chk("t5_rst_busy", {31'd0, busy}, 0);
    chk("t5_rst_count", {16'd0, instr_count}, 0);
    @(negedge clk); reset = 1'b0;
    do_start(8'h20);
    wait_idle("t5");
    chk("t5_pc", {24'd0, pc}, 32'h22);
    chk("t5_count", {16'd0, instr_count}, 2);
    chk("t5_halted", {31'd0, halted}, 1);

`ifdef BITTY_SINGLE_STEP_EN
    step = 1'b0;
    mem[8'h30] = 16'h0101; mem[8'h31] = 16'h0202; mem[8'h32] = 16'hFFFF;
    snap();
    do_start(8'h30);
    wait_run(1'b1, "t6a");
    wait_run(1'b0, "t6b");
    repeat (4) @(negedge clk);
    chk("t6_pause_busy", {31'd0, busy}, 1);
    chk("t6_pause_rd", rd_count - b_rd, 1);
    chk("t6_pause_pc", {24'd0, pc}, 32'h31);
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
    wait_run(1'b1, "t6c");
    wait_run(1'b0, "t6d");
    repeat (4) @(negedge clk);
    chk("t6_pause2_busy", {31'd0, busy}, 1);
    chk("t6_pause2_rd", rd_count - b_rd, 2);
    step = 1'b1; halt_req = 1'b1;
    @(negedge clk);
    step = 1'b0; halt_req = 1'b0;
    @(negedge clk);
    chk("t6_halted", {31'd0, halted}, 1);
    chk("t6_busy", {31'd0, busy}, 0);
    chk("t6_pc", {24'd0, pc}, 32'h32);
    chk("t6_count", {16'd0, instr_count}, 2);
    chk("t6_rd", rd_count - b_rd, 2);
    step = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
